inst_queue: RTL and testbench

Instruction buffer between instruction fetch (IF) and decode/issue. It accepts fetched instructions with their PC and branch-prediction bit, and buffers them in a circular FIFO. It releases at most one per cycle as a single-cycle valid pulse to the decoder, which drives `ID_valid` into issue. It back-pressures IF when full, withholds output while the ROB, RS or SLB is full, and discards all contents on a branch-mispredict flush.

---
 rtl/inst_queue.sv | 85 ++++++++
 tb/tb_inst_queue.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Instruction buffer between fetch and decode. Circular FIFO holding the instruction word, PC and prediction bit.
// Latency: one cycle from the push edge to the out_valid pulse; there is no same-cycle bypass.
// Backpressure: iq_full holds IF; stall withholds the next pop; rdy low freezes all state; jump_rst flushes.
module inst_queue #(
    parameter int IQ_SIZE_LOG = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   jump_rst,
    input  logic                   stall,
    input  logic                   IF_valid,
    input  logic [31:0]            IF_inst,
    input  logic [31:0]            IF_curPC,
    input  logic                   IF_pred_result,
    output logic                   iq_full,
    output logic [IQ_SIZE_LOG:0]   iq_count,
    output logic                   out_valid,
    output logic [31:0]            out_inst,
    output logic [31:0]            out_curPC,
    output logic                   out_pred
);

    localparam int DEPTH = 1 << IQ_SIZE_LOG;
    localparam logic [IQ_SIZE_LOG:0] FULL_CNT = (IQ_SIZE_LOG + 1)'(DEPTH);

    logic [31:0]            inst [DEPTH];
    logic [31:0]            pc   [DEPTH];
    logic                   pred [DEPTH];

    logic [IQ_SIZE_LOG-1:0] head;
    logic [IQ_SIZE_LOG-1:0] tail;
    logic [IQ_SIZE_LOG:0]   count;
    logic                   push;
    logic                   pop;

    assign iq_full  = (count == FULL_CNT);
    assign iq_count = count;

    // Both decisions use the pre-edge count, so a pop while full does not open a slot for this cycle's push.
    assign push = IF_valid && !iq_full && rdy && !rst && !jump_rst;
    assign pop  = (count != '0) && !stall && rdy && !rst && !jump_rst;

    // Storage is never cleared; head/tail/count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            inst[tail] <= IF_inst;
            pc[tail]   <= IF_curPC;
            pred[tail] <= IF_pred_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_curPC <= '0;
            out_pred  <= 1'b0;
        end else if (jump_rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else if (rdy) begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            // Decode consumes out_valid unconditionally; the data buses keep their last values between pulses.
            if (pop) begin
                out_inst  <= inst[head];
                out_curPC <= pc[head];
                out_pred  <= pred[head];
                out_valid <= 1'b1;
                head      <= head + 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
            count <= count + (IQ_SIZE_LOG + 1)'(push) - (IQ_SIZE_LOG + 1)'(pop);
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: table-driven opening sequence plus hand-written corner cases,
// with a scoreboard queue of accepted instructions compared against every decode pulse.
module tb_inst_queue;

    localparam int LOG   = 4;
    localparam int DEPTH = 1 << LOG;

    logic           clk;
    logic           rst;
    logic           rdy;
    logic           jump_rst;
    logic           stall;
    logic           IF_valid;
    logic [31:0]    IF_inst;
    logic [31:0]    IF_curPC;
    logic           IF_pred_result;
    logic           iq_full;
    logic [LOG:0]   iq_count;
    logic           out_valid;
    logic [31:0]    out_inst;
    logic [31:0]    out_curPC;
    logic           out_pred;

    inst_queue #(.IQ_SIZE_LOG(LOG)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .jump_rst       (jump_rst),
        .stall          (stall),
        .IF_valid       (IF_valid),
        .IF_inst        (IF_inst),
        .IF_curPC       (IF_curPC),
        .IF_pred_result (IF_pred_result),
        .iq_full        (iq_full),
        .iq_count       (iq_count),
        .out_valid      (out_valid),
        .out_inst       (out_inst),
        .out_curPC      (out_curPC),
        .out_pred       (out_pred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } entry_t;

    typedef struct {
        bit          vld;
        logic [31:0] pc;
        bit          pred;
        bit          stl;
        bit          e_vld;
        logic [31:0] e_pc;
        bit          e_pred;
        int          e_cnt;
    } vec_t;

    entry_t      sb[$];
    int          mcount = 0;
    bit          exp_valid = 0;
    logic [31:0] exp_inst = 0;
    logic [31:0] exp_pc = 0;
    logic        exp_pred = 0;
    int          checks = 0;
    int          errors = 0;
    int          obs_pops = 0;

    function automatic logic [31:0] mkinst(input logic [31:0] p);
        return {16'hC0DE, p[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] p, input bit pr, input bit st);
        IF_valid       = v;
        IF_curPC       = p;
        IF_inst        = mkinst(p);
        IF_pred_result = pr;
        stall          = st;
    endtask

    // One clock: predict this edge's push/pop from the model, then compare everything #1 after the edge.
    task automatic tick();
        bit     c_push, c_pop, c_rdy, c_rst, c_jr;
        entry_t e, o;
        c_rst  = rst;
        c_jr   = jump_rst;
        c_rdy  = rdy;
        c_push = IF_valid && (mcount != DEPTH) && rdy && !rst && !jump_rst;
        c_pop  = (mcount != 0) && !stall && rdy && !rst && !jump_rst;
        e      = '{inst: IF_inst, pc: IF_curPC, pred: IF_pred_result};
        @(posedge clk);
        #1;
        if (c_rst) begin
            mcount = 0; sb.delete(); exp_valid = 0;
            exp_inst = 0; exp_pc = 0; exp_pred = 0;
        end else if (c_jr) begin
            mcount = 0; sb.delete(); exp_valid = 0;
        end else if (c_rdy) begin
            exp_valid = c_pop;
            if (c_pop && sb.size() > 0) begin
                o = sb.pop_front();
                exp_inst = o.inst; exp_pc = o.pc; exp_pred = o.pred;
            end
            if (c_push) sb.push_back(e);
            mcount = mcount + int'(c_push) - int'(c_pop);
        end
        chk("sb_out_valid", 32'(out_valid), 32'(exp_valid));
        chk("sb_iq_count", 32'(iq_count), 32'(mcount));
        chk("sb_iq_full", 32'(iq_full), 32'(mcount == DEPTH));
        chk("sb_out_curPC", out_curPC, exp_pc);
        chk("sb_out_inst", out_inst, exp_inst);
        chk("sb_out_pred", 32'(out_pred), 32'(exp_pred));
        if (out_valid && c_rdy && !c_rst && !c_jr) obs_pops++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[5];
        vt[0] = '{1, 32'h0, 0, 0,  0, 32'h0, 0, 1};
        vt[1] = '{1, 32'h4, 1, 0,  1, 32'h0, 0, 1};
        vt[2] = '{1, 32'h8, 0, 0,  1, 32'h4, 1, 1};
        vt[3] = '{0, 32'h0, 0, 0,  1, 32'h8, 0, 0};
        vt[4] = '{0, 32'h0, 0, 0,  0, 32'h8, 0, 0};

        rst = 1; rdy = 1; jump_rst = 0;
        drive(0, 32'h0, 0, 0);
        tick();
        tick();
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_out_curPC", out_curPC, 32'h0);
        chk("reset_out_inst", out_inst, 32'h0);
        chk("reset_iq_count", 32'(iq_count), 32'h0);
        chk("reset_iq_full", 32'(iq_full), 32'h0);
        rst = 0;

        // Three pushes into an empty queue: pulses on three consecutive cycles, one cycle after each push.
        for (int i = 0; i < 5; i++) begin
            drive(vt[i].vld, vt[i].pc, vt[i].pred, vt[i].stl);
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].e_vld));
            chk($sformatf("vec%0d_pc", i), out_curPC, vt[i].e_pc);
            chk($sformatf("vec%0d_pred", i), 32'(out_pred), 32'(vt[i].e_pred));
            chk($sformatf("vec%0d_count", i), 32'(iq_count), 32'(vt[i].e_cnt));
            if (vt[i].e_vld) chk($sformatf("vec%0d_inst", i), out_inst, mkinst(vt[i].e_pc));
        end

        // Fill under stall, refuse a 17th, then drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 32'h200 + 32'(4 * i), i[0], 1);
            tick();
        end
        chk("fill_iq_full", 32'(iq_full), 32'h1);
        chk("fill_iq_count", 32'(iq_count), 32'd16);
        drive(1, 32'hDEAD0, 1, 1);
        tick();
        chk("overflow_iq_count", 32'(iq_count), 32'd16);
        obs_pops = 0;
        drive(0, 32'h0, 0, 0);
        tick();
        chk("drain_first_valid", 32'(out_valid), 32'h1);
        chk("drain_first_pc", out_curPC, 32'h200);
        chk("drain_full_drop", 32'(iq_full), 32'h0);
        chk("drain_first_count", 32'(iq_count), 32'd15);
        repeat (15) tick();
        chk("drain_pops", 32'(obs_pops), 32'd16);
        tick();
        chk("drain_idle_valid", 32'(out_valid), 32'h0);

        // Flush with a pulse in flight and a concurrent push.
        for (int i = 0; i < 11; i++) begin
            drive(1, 32'h300 + 32'(4 * i), 0, 1);
            tick();
        end
        drive(0, 32'h0, 0, 0);
        tick();
        chk("preflush_count", 32'(iq_count), 32'd10);
        chk("preflush_valid", 32'(out_valid), 32'h1);
        jump_rst = 1;
        drive(1, 32'h9990, 1, 0);
        tick();
        chk("flush_count", 32'(iq_count), 32'h0);
        chk("flush_valid", 32'(out_valid), 32'h0);
        jump_rst = 0;
        drive(1, 32'h100, 1, 0);
        tick();
        chk("postflush_count", 32'(iq_count), 32'h1);
        drive(0, 32'h0, 0, 0);
        tick();
        chk("postflush_valid", 32'(out_valid), 32'h1);
        chk("postflush_pc", out_curPC, 32'h100);
        chk("postflush_pred", 32'(out_pred), 32'h1);

        // Continuous streaming across two pointer wraps.
        for (int i = 0; i < 40; i++) begin
            drive(1, 32'(4 * i), (i % 3) == 0, 0);
            tick();
            if (i > 0) begin
                chk($sformatf("stream%0d_pc", i), out_curPC, 32'(4 * (i - 1)));
                chk($sformatf("stream%0d_count", i), 32'(iq_count), 32'h1);
            end
        end
        drive(0, 32'h0, 0, 0);
        tick();
        chk("stream_last_pc", out_curPC, 32'h9C);
        tick();

        // Freeze with a pulse held and fetch still presenting.
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h400 + 32'(4 * i), i[0], 1);
            tick();
        end
        drive(0, 32'h0, 0, 0);
        tick();
        chk("prefreeze_count", 32'(iq_count), 32'd4);
        chk("prefreeze_valid", 32'(out_valid), 32'h1);
        rdy = 0;
        obs_pops = 0;
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h500 + 32'(4 * k), 1, 0);
            tick();
            chk($sformatf("freeze%0d_count", k), 32'(iq_count), 32'd4);
            chk($sformatf("freeze%0d_valid", k), 32'(out_valid), 32'h1);
            chk($sformatf("freeze%0d_pc", k), out_curPC, 32'h400);
        end
        rdy = 1;
        drive(0, 32'h0, 0, 0);
        repeat (4) tick();
        chk("thaw_pops", 32'(obs_pops), 32'd4);
        chk("thaw_last_pc", out_curPC, 32'h410);
        tick();
        chk("thaw_idle_count", 32'(iq_count), 32'h0);

        // Synchronous reset mid-stream with five entries held.
        for (int i = 0; i < 6; i++) begin
            drive(1, 32'h600 + 32'(4 * i), 1, 1);
            tick();
        end
        drive(0, 32'h0, 0, 0);
        tick();
        chk("prerst_count", 32'(iq_count), 32'd5);
        rst = 1;
        drive(1, 32'h700, 1, 0);
        tick();
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_pc", out_curPC, 32'h0);
        chk("midrst_inst", out_inst, 32'h0);
        chk("midrst_pred", 32'(out_pred), 32'h0);
        chk("midrst_count", 32'(iq_count), 32'h0);
        rst = 0;
        drive(1, 32'h800, 0, 0);
        tick();
        drive(0, 32'h0, 0, 0);
        tick();
        chk("postrst_pc", out_curPC, 32'h800);
        tick();
        chk("postrst_count", 32'(iq_count), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
